// File: rtl/word_split.sv
// word_split
//   Narrows a 32-bit datapath word into 5-bit slices for narrow consumers
//   (shift amounts, register indices) or for streaming a value out 5 bits at
//   a time. This is the inverse of the 5->32 zero-extender.
//
//   FULL mode  : every slice is emitted, least significant slice first.
//   TRUNC mode : only the low slice is emitted. out_ovf flags any discarded
//                nonzero bits above it.
//
//   The input and output sides do not overlap. A new word is accepted only
//   when the previous word has been fully drained. The minimum cost is
//   NSLICE+1 cycles per word in FULL mode and 2 cycles per word in TRUNC mode.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | waiting for a word; in_ready=1 (outside reset), out_valid=0
//   EMIT  | presenting shreg's low slice; in_ready=0, out_valid=1
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous reset, active high
//   in_valid   in   in_word/in_trunc valid
//   in_ready   out  a word can be accepted this cycle
//   in_word    in   word to split
//   in_trunc   in   1 = TRUNC mode, 0 = FULL mode (sampled with the word)
//   out_valid  out  out_* fields valid
//   out_ready  in   consumer takes the current slice
//   out_slice  out  bits [OUT_W*out_idx +: OUT_W] of the word, zero padded
//   out_idx    out  slice index, 0..NSLICE-1
//   out_last   out  current slice is the final one for this word
//   out_ovf    out  TRUNC only: bits above the low slice were nonzero

module word_split #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_word,
    input  logic             in_trunc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_slice,
    output logic [2:0]       out_idx,
    output logic             out_last,
    output logic             out_ovf
);

    localparam int         NSLICE   = (IN_W + OUT_W - 1) / OUT_W;
    localparam logic [2:0] LAST_IDX = 3'(NSLICE - 1);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [IN_W-1:0] shreg;
    logic [2:0]      idx;
    logic            trunc_q;
    logic            ovf_q;

    logic            accept;
    logic            fire;
    logic            is_last;
    logic            ovf_in;

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    // in_ready is forced low while rst is high. This ensures that an upstream
    // producer never sees a handshake complete in a cycle that reset discards.
    always_comb begin
        in_ready = (state == IDLE) & ~rst;
        accept   = in_valid & in_ready;
        is_last  = trunc_q | (idx == LAST_IDX);
        fire     = (state == EMIT) & out_ready;
        ovf_in   = in_trunc & (|in_word[IN_W-1:OUT_W]);
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = EMIT;
                end
            end
            EMIT: begin
                if (fire && is_last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: shift register, slice index, latched mode and overflow
    // ------------------------------------------------------------------
    // The word shifts right with zero fill. As a result, the final slice
    // carries only the remaining top bits, and its upper bits are already 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg   <= '0;
            idx     <= '0;
            trunc_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            shreg   <= in_word;
            idx     <= '0;
            trunc_q <= in_trunc;
            ovf_q   <= ovf_in;
        end else if (fire && !is_last) begin
            shreg   <= shreg >> OUT_W;
            idx     <= idx + 3'd1;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // The output fields are gated with out_valid so that they read as zero
    // in IDLE. This holds after reset as well as after a word has drained.
    // While stalled, every field is a function of held registers only, so
    // all fields stay stable under backpressure.
    always_comb begin
        out_valid = (state == EMIT);
        out_slice = out_valid ? shreg[OUT_W-1:0] : '0;
        out_idx   = out_valid ? idx : 3'd0;
        out_last  = out_valid & is_last;
        out_ovf   = out_valid & ovf_q;
    end

endmodule

// File: tb/tb_word_split.sv
module tb_word_split;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_word;
    logic        in_trunc;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_slice;
    logic [2:0]  out_idx;
    logic        out_last;
    logic        out_ovf;

    int total = 0;
    int bad   = 0;

    word_split #(.IN_W(32), .OUT_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_word   (in_word),
        .in_trunc  (in_trunc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_slice (out_slice),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model. Slice i is the word divided by 32^i, modulo 32.
    function automatic logic [31:0] ref_slice(input logic [31:0] w, input int i);
        return (w >> (5 * i)) % 32;
    endfunction

    function automatic int ref_count(input logic t);
        return t ? 1 : 7;
    endfunction

    function automatic logic ref_ovf(input logic [31:0] w, input logic t);
        return t && (w >= 32);
    endfunction

    // Checks all visible outputs for slice i of word w.
    task automatic chk_slice(input string tg, input logic [31:0] w, input logic t, input int i);
        int n;
        n = ref_count(t);
        chk($sformatf("%s valid[%0d]", tg, i), 32'(out_valid), 1);
        chk($sformatf("%s in_ready[%0d]", tg, i), 32'(in_ready), 0);
        chk($sformatf("%s slice[%0d]", tg, i), 32'(out_slice), ref_slice(w, i));
        chk($sformatf("%s idx[%0d]", tg, i), 32'(out_idx), 32'(i));
        chk($sformatf("%s last[%0d]", tg, i), 32'(out_last), 32'(i == n - 1));
        chk($sformatf("%s ovf[%0d]", tg, i), 32'(out_ovf), 32'(ref_ovf(w, t)));
    endtask

    // Sends a word and consumes its slices, sampling and driving at the negedge.
    // stall_idx/stall_n : hold out_ready low for stall_n cycles at that slice
    // rnd_stall         : random 0..2 stall cycles at each slice instead
    // hold_in           : keep in_valid high (with a different word) during emission
    // abort_idx         : apply reset while presenting that slice (-1 = none)
    task automatic run_word(input string tg, input logic [31:0] w, input logic t,
                            input int stall_idx, input int stall_n, input bit rnd_stall,
                            input bit hold_in, input int abort_idx);
        int n;
        int st;
        n = ref_count(t);
        chk({tg, " in_ready pre"}, 32'(in_ready), 1);
        in_valid = 1'b1;
        in_word  = w;
        in_trunc = t;
        out_ready = 1'b1;
        @(negedge clk);
        if (hold_in) begin
            in_word  = ~w;
            in_trunc = ~t;
        end else begin
            in_valid = 1'b0;
        end
        for (int i = 0; i < n; i++) begin
            chk_slice(tg, w, t, i);
            if (i == abort_idx) begin
                rst = 1'b1;
                in_valid = 1'b0;
                @(negedge clk);
                chk({tg, " abort valid"}, 32'(out_valid), 0);
                chk({tg, " abort in_ready"}, 32'(in_ready), 0);
                chk({tg, " abort slice"}, 32'(out_slice), 0);
                chk({tg, " abort idx"}, 32'(out_idx), 0);
                rst = 1'b0;
                @(negedge clk);
                chk({tg, " post-abort valid"}, 32'(out_valid), 0);
                chk({tg, " post-abort in_ready"}, 32'(in_ready), 1);
                return;
            end
            st = rnd_stall ? int'($urandom_range(0, 2)) : ((i == stall_idx) ? stall_n : 0);
            if (st > 0) begin
                out_ready = 1'b0;
                for (int k = 0; k < st; k++) begin
                    @(negedge clk);
                    chk_slice({tg, " held"}, w, t, i);
                end
                out_ready = 1'b1;
            end
            if (i == n - 1) in_valid = 1'b0;
            @(negedge clk);
        end
        chk({tg, " done valid"}, 32'(out_valid), 0);
        chk({tg, " done in_ready"}, 32'(in_ready), 1);
    endtask

    initial begin
        logic [31:0] w;
        logic        t;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_word   = '0;
        in_trunc  = 1'b0;
        out_ready = 1'b0;

        // Reset held for two cycles
        @(negedge clk);
        @(negedge clk);
        chk("rst in_ready", 32'(in_ready), 0);
        chk("rst out_valid", 32'(out_valid), 0);
        chk("rst slice", 32'(out_slice), 0);
        chk("rst idx", 32'(out_idx), 0);
        chk("rst last", 32'(out_last), 0);
        chk("rst ovf", 32'(out_ovf), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post-rst in_ready", 32'(in_ready), 1);
        chk("post-rst out_valid", 32'(out_valid), 0);

        // Directed vectors
        run_word("full1234", 32'h12345678, 1'b0, -1, 0, 1'b0, 1'b0, -1);
        run_word("fullFFFF", 32'hFFFFFFFF, 1'b0, -1, 0, 1'b0, 1'b0, -1);
        run_word("trunc1A", 32'h0000001A, 1'b1, -1, 0, 1'b0, 1'b0, -1);
        run_word("trunc20", 32'h00000020, 1'b1, -1, 0, 1'b0, 1'b0, -1);
        run_word("stall", 32'h12345678, 1'b0, 2, 3, 1'b0, 1'b1, -1);
        run_word("abort", 32'h12345678, 1'b0, -1, 0, 1'b0, 1'b0, 3);
        run_word("after3F", 32'h0000003F, 1'b0, -1, 0, 1'b0, 1'b0, -1);
        run_word("truncFF", 32'hFFFFFFFF, 1'b1, 0, 2, 1'b0, 1'b1, -1);

        // Randomized words, modes and backpressure
        for (int r = 0; r < 40; r++) begin
            w = $urandom;
            t = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) == 0) w = w & 32'h1F;
            run_word($sformatf("rnd%0d", r), w, t, -1, 0, 1'b1, bit'($urandom_range(0, 1)), -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
